// File: rtl/debug_dump_sequencer.sv
// Streams the PC, the register file and the data memory out over a UART byte
// interface, one word at a time, least-significant byte first.
module debug_dump_sequencer #(
  parameter int NB_DATA     = 32,
  parameter int NB_BYTE     = 8,
  parameter int NB_ADDR     = 5,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_pc,
  output logic [NB_ADDR-1:0] o_reg_addr,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic [NB_ADDR-1:0] o_mem_addr,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic               i_tx_done_tick,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_BIDX = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(BYTES_PER_WORD - 1);
  localparam logic [NB_ADDR-1:0] LAST_REG  = NB_ADDR'(N_REGS - 1);
  localparam logic [NB_ADDR-1:0] LAST_MEM  = NB_ADDR'(N_MEM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, WAIT_TX, DONE} state_t;
  typedef enum logic [1:0] {SEC_PC, SEC_REG, SEC_MEM} section_t;

  state_t             state_q, state_d;
  section_t           section_q, section_d;
  logic [NB_ADDR-1:0] wordIdx_q, wordIdx_d;
  logic [NB_BIDX-1:0] byteIdx_q, byteIdx_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_ADDR-1:0] regAddr_q, regAddr_d;
  logic [NB_ADDR-1:0] memAddr_q, memAddr_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      section_q <= SEC_PC;
      wordIdx_q <= '0;
      byteIdx_q <= '0;
      shift_q   <= '0;
      regAddr_q <= '0;
      memAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      section_q <= section_d;
      wordIdx_q <= wordIdx_d;
      byteIdx_q <= byteIdx_d;
      shift_q   <= shift_d;
      regAddr_q <= regAddr_d;
      memAddr_q <= memAddr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    section_d = section_q;
    wordIdx_d = wordIdx_q;
    byteIdx_d = byteIdx_q;
    shift_d   = shift_q;
    regAddr_d = regAddr_q;
    memAddr_d = memAddr_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = FETCH;
          section_d = SEC_PC;
          wordIdx_d = '0;
          byteIdx_d = '0;
        end
      end
      FETCH: begin
        state_d = LATCH;
        if (section_q == SEC_REG) regAddr_d = wordIdx_q;
        else if (section_q == SEC_MEM) memAddr_d = wordIdx_q;
      end
      LATCH: begin
        state_d = SEND;
        case (section_q)
          SEC_REG: shift_d = i_reg_data;
          SEC_MEM: shift_d = i_mem_data;
          default: shift_d = i_pc;
        endcase
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done_tick) begin
          if (byteIdx_q != LAST_BYTE) begin
            byteIdx_d = byteIdx_q + NB_BIDX'(1);
            shift_d   = shift_q >> NB_BYTE;
            state_d   = SEND;
          end else begin
            // Word finished: move to the next word, section, or finish the dump.
            byteIdx_d = '0;
            wordIdx_d = '0;
            state_d   = FETCH;
            case (section_q)
              SEC_PC: section_d = SEC_REG;
              SEC_REG: begin
                if (wordIdx_q == LAST_REG) section_d = SEC_MEM;
                else wordIdx_d = wordIdx_q + NB_ADDR'(1);
              end
              default: begin
                if (wordIdx_q == LAST_MEM) state_d = DONE;
                else wordIdx_d = wordIdx_q + NB_ADDR'(1);
              end
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The address is presented during FETCH itself so read data is ready in LATCH.
  assign o_reg_addr = (state_q == FETCH && section_q == SEC_REG) ? wordIdx_q : regAddr_q;
  assign o_mem_addr = (state_q == FETCH && section_q == SEC_MEM) ? wordIdx_q : memAddr_q;
  assign o_tx_start = (state_q == SEND);
  assign o_tx_data  = shift_q[NB_BYTE-1:0];
  assign o_busy     = (state_q != IDLE) && (state_q != DONE);
  assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Self-checking bench: a byte-queue reference model of the dump stream, a UART
// responder with programmable latency, and register/memory read models.
module tb_debug_dump_sequencer;
  localparam int N_REGS = 32;
  localparam int N_MEM  = 32;
  localparam int TOTAL  = 4 * (1 + N_REGS + N_MEM);

  logic        clock = 1'b0;
  logic        reset, start, txDoneTick;
  logic [31:0] pc, regData, memData;
  logic [4:0]  regAddr, memAddr;
  logic        txStart, busy, done;
  logic [7:0]  txData;

  logic [31:0] regFile [0:N_REGS-1];
  logic [31:0] memFile [0:N_MEM-1];

  int checkCount = 0;
  int passCount  = 0;
  int sentCount, doneCount, countdown;
  int startAt, resetAt, holdAt;
  bit randomDelay, spuriousSend, resetFired;
  logic [7:0] lastByte;
  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];

  always #5 clock = ~clock;

  debug_dump_sequencer #(
    .NB_DATA(32), .NB_BYTE(8), .NB_ADDR(5), .N_REGS(N_REGS), .N_MEM_WORDS(N_MEM)
  ) dut (
    .i_clock(clock), .i_reset(reset), .i_start(start), .i_pc(pc),
    .o_reg_addr(regAddr), .i_reg_data(regData),
    .o_mem_addr(memAddr), .i_mem_data(memData),
    .i_tx_done_tick(txDoneTick), .o_tx_start(txStart), .o_tx_data(txData),
    .o_busy(busy), .o_done(done)
  );

  // Synchronous-read register file and data memory: data one cycle after address.
  always @(posedge clock) begin
    regData <= regFile[regAddr];
    memData <= memFile[memAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) expQ.push_back(8'((w >> (8 * i)) & 32'hFF));
  endtask

  task automatic buildExpected();
    expQ.delete();
    gotQ.delete();
    pushWord(pc);
    for (int k = 0; k < N_REGS; k++) pushWord(regFile[k]);
    for (int k = 0; k < N_MEM; k++) pushWord(memFile[k]);
  endtask

  // One clock: sample outputs after the edge, then drive the next inputs.
  task automatic tick();
    logic [7:0] expByte;
    @(posedge clock);
    #1;
    start      = 1'b0;
    txDoneTick = 1'b0;
    reset      = 1'b0;
    if (txStart) begin
      checkOutput("busyDuringSend", busy, 1);
      if (expQ.size() == 0) checkOutput("extraTxStart", txStart, 0);
      else begin
        expByte = expQ.pop_front();
        checkOutput("txByte", txData, expByte);
      end
      gotQ.push_back(txData);
      lastByte = txData;
      sentCount++;
      if (sentCount == holdAt) countdown = 50;
      else if (randomDelay) countdown = $urandom_range(1, 12);
      else countdown = 8;
      if (spuriousSend) txDoneTick = 1'b1;
      if (sentCount == startAt) start = 1'b1;
      if (sentCount == resetAt) begin
        reset      = 1'b1;
        start      = 1'b1;
        txDoneTick = 1'b1;
        countdown  = 0;
        resetFired = 1'b1;
      end
    end else if (countdown > 0) begin
      checkOutput("holdNoStart", txStart, 0);
      checkOutput("holdData", txData, lastByte);
      checkOutput("holdBusy", busy, 1);
      countdown--;
      if (countdown == 0) txDoneTick = 1'b1;
    end
    if (done) begin
      doneCount++;
      checkOutput("doneBusyLow", busy, 0);
      checkOutput("doneByteCount", sentCount, TOTAL);
      checkOutput("doneQueueEmpty", expQ.size(), 0);
    end
  endtask

  task automatic applyStimulus(input int maxCycles);
    int cycles = 0;
    int doneBefore = doneCount;
    sentCount  = 0;
    countdown  = 0;
    resetFired = 1'b0;
    start = 1'b1;
    tick();
    checkOutput("busyAfterStart", busy, 1);
    while (doneCount == doneBefore && !resetFired && cycles < maxCycles) begin
      tick();
      cycles++;
    end
    if (!resetFired) checkOutput("dumpCompleted", doneCount - doneBefore, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; txDoneTick = 1'b0; pc = '0;
    startAt = -1; resetAt = -1; holdAt = -1;
    randomDelay = 1'b0; spuriousSend = 1'b0;
    doneCount = 0; countdown = 0; sentCount = 0; lastByte = '0;
    for (int k = 0; k < N_REGS; k++) regFile[k] = '0;
    for (int k = 0; k < N_MEM; k++) memFile[k] = '0;
    tick();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstTxStart", txStart, 0);
    checkOutput("rstTxData", txData, 0);
    checkOutput("rstRegAddr", regAddr, 0);
    checkOutput("rstMemAddr", memAddr, 0);

    // Done ticks while idle must not start anything.
    for (int i = 0; i < 3; i++) begin
      txDoneTick = 1'b1;
      tick();
      checkOutput("idleTickBusy", busy, 0);
      checkOutput("idleTickStart", txStart, 0);
    end

    // Directed dump with the reference pattern.
    pc = 32'h0000_0010;
    for (int k = 0; k < N_REGS; k++) regFile[k] = k;
    for (int k = 0; k < N_MEM; k++) memFile[k] = 32'h100 + k;
    buildExpected();
    applyStimulus(20000);
    checkOutput("d1Size", gotQ.size(), TOTAL);
    checkOutput("d1Byte0", gotQ[0], 8'h10);
    checkOutput("d1Byte1", gotQ[1], 8'h00);
    checkOutput("d1Byte4", gotQ[4], 8'h00);
    checkOutput("d1Byte8", gotQ[8], 8'h01);
    checkOutput("d1LastB0", gotQ[TOTAL-4], 8'h1F);
    checkOutput("d1LastB1", gotQ[TOTAL-3], 8'h01);
    checkOutput("d1LastB3", gotQ[TOTAL-1], 8'h00);
    checkOutput("d1RegAddrHeld", regAddr, N_REGS - 1);
    checkOutput("d1MemAddrHeld", memAddr, N_MEM - 1);
    tick();
    checkOutput("d1DonePulse", done, 0);
    checkOutput("d1DoneCount", doneCount, 1);

    // Random data, random latency, spurious ticks in SEND, stray start, long hold.
    pc = $urandom;
    for (int k = 0; k < N_REGS; k++) regFile[k] = $urandom;
    for (int k = 0; k < N_MEM; k++) memFile[k] = $urandom;
    regFile[5] = 32'hDEAD_BEEF;
    randomDelay = 1'b1; spuriousSend = 1'b1; startAt = 37; holdAt = 120;
    buildExpected();
    applyStimulus(20000);
    checkOutput("d2Size", gotQ.size(), TOTAL);
    checkOutput("d2Off24", gotQ[24], 8'hEF);
    checkOutput("d2Off25", gotQ[25], 8'hBE);
    checkOutput("d2Off26", gotQ[26], 8'hAD);
    checkOutput("d2Off27", gotQ[27], 8'hDE);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("d2DoneCount", doneCount, 2);

    // Reset with start and tick asserted at byte 100, then a clean restart.
    pc = $urandom;
    for (int k = 0; k < N_REGS; k++) regFile[k] = $urandom;
    for (int k = 0; k < N_MEM; k++) memFile[k] = $urandom;
    spuriousSend = 1'b0; startAt = -1; holdAt = -1; resetAt = 100;
    buildExpected();
    applyStimulus(20000);
    checkOutput("d3ResetReached", sentCount, 100);
    tick();
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortTxStart", txStart, 0);
    checkOutput("abortTxData", txData, 0);
    checkOutput("abortRegAddr", regAddr, 0);
    checkOutput("abortMemAddr", memAddr, 0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("abortNoDone", doneCount, 2);
    resetAt = -1;
    buildExpected();
    applyStimulus(20000);
    checkOutput("d3Size", gotQ.size(), TOTAL);
    checkOutput("d3FirstByte", gotQ[0], pc[7:0]);
    checkOutput("d3DoneCount", doneCount, 3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
